tt_um_hoene_manchester_rx: RTL and testbench



---
 rtl/tt_um_hoene_manchester_rx_pkg.sv | 16 +
 rtl/tt_um_hoene_edge_timer.sv | 92 +++++++++
 rtl/tt_um_hoene_manchester_rx.sv | 149 ++++++++++++++
 tb/tb_tt_um_hoene_manchester_rx.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/tt_um_hoene_manchester_rx_pkg.sv
// Shared encodings for the Manchester receiver.
// FSM states, line polarity choices and interval classes.
package tt_um_hoene_manchester_rx_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MID   = 2'd1;
    localparam logic [1:0] ST_BOUND = 2'd2;

    localparam int POLARITY_IEEE   = 0;
    localparam int POLARITY_THOMAS = 1;

    localparam logic [1:0] CLS_SHORT = 2'd0;
    localparam logic [1:0] CLS_LONG  = 2'd1;
    localparam logic [1:0] CLS_BAD   = 2'd2;

endpackage

// File: rtl/tt_um_hoene_edge_timer.sv
// Line synchroniser, edge detector and edge-to-edge interval timer.
// Edge, direction and interval class are registered together.
module tt_um_hoene_edge_timer
    import tt_um_hoene_manchester_rx_pkg::*;
#(
    parameter int HALF_BIT     = 8,
    parameter int IDLE_TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       line_i,
    output logic       edge_o,
    output logic       rising_o,
    output logic [1:0] class_o,
    output logic       timeout_o
);

    localparam int CW = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [CW-1:0] SHORT_MIN = CW'(HALF_BIT / 2);
    localparam logic [CW-1:0] LONG_MIN  = CW'((3 * HALF_BIT) / 2);
    localparam logic [CW-1:0] LONG_MAX  = CW'((5 * HALF_BIT) / 2);
    localparam logic [CW-1:0] CNT_MAX   = CW'(IDLE_TIMEOUT);

    logic          sync1_q;
    logic          sync2_q;
    logic          prev_q;
    logic [CW-1:0] cnt_q;
    logic          edge_q;
    logic          rising_q;
    logic [1:0]    class_q;
    logic          edge_w;
    logic [1:0]    class_w;

    assign edge_w = sync2_q ^ prev_q;

    // Classify the interval that ends at the current edge.
    always_comb begin
        class_w = CLS_BAD;
        unique case (1'b1)
            (cnt_q >= SHORT_MIN) && (cnt_q < LONG_MIN):
                class_w = CLS_SHORT;
            (cnt_q >= LONG_MIN) && (cnt_q <= LONG_MAX):
                class_w = CLS_LONG;
            default:
                class_w = CLS_BAD;
        endcase
    end

    // Synchronise the line and remember its previous level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Interval counter: restarts on each edge, saturates at the idle limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (edge_w) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Register the edge event with its direction and interval class.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_q   <= 1'b0;
            rising_q <= 1'b0;
            class_q  <= CLS_SHORT;
        end else begin
            edge_q   <= edge_w;
            rising_q <= edge_w & sync2_q;
            class_q  <= class_w;
        end
    end

    assign edge_o    = edge_q;
    assign rising_o  = rising_q;
    assign class_o   = class_q;
    assign timeout_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/tt_um_hoene_manchester_rx.sv
// Manchester receiver: FSM on classified edges, MSB-first word assembly.
// Emits word, frame-end and error pulses one cycle after the deciding event.
module tt_um_hoene_manchester_rx
    import tt_um_hoene_manchester_rx_pkg::*;
#(
    parameter int DATA_WIDTH   = 24,
    parameter int HALF_BIT     = 8,
    parameter int IDLE_TIMEOUT = 32,
    parameter int POLARITY     = POLARITY_IEEE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_frame_end,
    output logic                  out_error,
    output logic                  out_busy
);

    localparam int BCW = $clog2(DATA_WIDTH + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);
    localparam logic POL_BIT = (POLARITY == POLARITY_THOMAS);

    logic                  edge_w;
    logic                  rising_w;
    logic [1:0]            class_w;
    logic                  timeout_w;
    logic                  bit_w;
    logic [DATA_WIDTH-1:0] word_w;

    logic [1:0]            state_q, state_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  fend_q, fend_d;
    logic                  err_q, err_d;

    tt_um_hoene_edge_timer #(
        .HALF_BIT     (HALF_BIT),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .line_i    (in),
        .edge_o    (edge_w),
        .rising_o  (rising_w),
        .class_o   (class_w),
        .timeout_o (timeout_w)
    );

    assign bit_w  = rising_w ^ POL_BIT;
    assign word_w = {shift_q[DATA_WIDTH-2:0], bit_w};

    // Next-state logic: decode edges into bits, words, errors and frame ends.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        fend_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (edge_w && rising_w) begin
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    state_d   = ST_MID;
                end
            end
            ST_MID: begin
                if (edge_w) begin
                    if (class_w == CLS_SHORT) begin
                        state_d = ST_BOUND;
                    end else if (class_w == CLS_LONG) begin
                        shift_d = word_w;
                        if (bit_cnt_q == LAST_BIT) begin
                            data_d    = word_w;
                            valid_d   = 1'b1;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        err_d     = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end
                end else if (timeout_w) begin
                    fend_d    = (bit_cnt_q == '0);
                    err_d     = (bit_cnt_q != '0);
                    bit_cnt_d = '0;
                    state_d   = ST_IDLE;
                end
            end
            ST_BOUND: begin
                if (edge_w && (class_w == CLS_SHORT)) begin
                    shift_d = word_w;
                    state_d = ST_MID;
                    if (bit_cnt_q == LAST_BIT) begin
                        data_d    = word_w;
                        valid_d   = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (edge_w || timeout_w) begin
                    err_d     = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                bit_cnt_d = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // Decoder state and registered output pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            fend_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            fend_q    <= fend_d;
            err_q     <= err_d;
        end
    end

    assign out_data      = data_q;
    assign out_valid     = valid_q;
    assign out_frame_end = fend_q;
    assign out_error     = err_q;
    assign out_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tt_um_hoene_manchester_rx.sv
// Directed bench for the Manchester receiver (8-bit words).
// IEEE-polarity and Thomas-polarity instances share one line.
module tb_tt_um_hoene_manchester_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       line = 1'b0;

    logic [7:0] d0_data, d1_data;
    logic       d0_valid, d1_valid;
    logic       d0_fend, d1_fend;
    logic       d0_err, d1_err;
    logic       d0_busy, d1_busy;

    int checks = 0;
    int failures = 0;

    int cyc = 0;
    int nv = 0, ne = 0, nf = 0;
    int v_cyc = 0, f_cyc = 0;
    logic err_busy = 1'b1;
    logic [7:0] vdata [0:15];

    int bv, be, bf;

    always #5 clk = ~clk;

    tt_um_hoene_manchester_rx #(
        .DATA_WIDTH (8),
        .POLARITY   (0)
    ) dut0 (
        .clk           (clk),
        .rst           (rst),
        .in            (line),
        .out_data      (d0_data),
        .out_valid     (d0_valid),
        .out_frame_end (d0_fend),
        .out_error     (d0_err),
        .out_busy      (d0_busy)
    );

    tt_um_hoene_manchester_rx #(
        .DATA_WIDTH (8),
        .POLARITY   (1)
    ) dut1 (
        .clk           (clk),
        .rst           (rst),
        .in            (line),
        .out_data      (d1_data),
        .out_valid     (d1_valid),
        .out_frame_end (d1_fend),
        .out_error     (d1_err),
        .out_busy      (d1_busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Record pulses of the IEEE instance away from the active edge.
    always @(negedge clk) begin
        if (d0_valid) begin
            vdata[nv[3:0]] <= d0_data;
            nv <= nv + 1;
            v_cyc <= cyc;
        end
        if (d0_err) begin
            ne <= ne + 1;
            err_busy <= d0_busy;
        end
        if (d0_fend) begin
            nf <= nf + 1;
            f_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic half(input logic lvl, input int n);
        line = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int h1, input int h2);
        half(~b, h1);
        half(b, h2);
    endtask

    task automatic send_frame(input logic [15:0] d, input int n);
        send_bit(1'b1, 8, 8);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(d[i], 8, 8);
        end
    endtask

    task automatic mark();
        bv = nv;
        be = ne;
        bf = nf;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", {24'd0, d0_data}, 32'h0);
        check("rst_valid", {31'd0, d0_valid}, 32'h0);
        check("rst_err", {31'd0, d0_err}, 32'h0);
        check("rst_fend", {31'd0, d0_fend}, 32'h0);
        check("rst_busy", {31'd0, d0_busy}, 32'h0);
        rst = 1'b0;
        half(1'b0, 40);

        mark();
        send_frame(16'h00A5, 8);
        half(line, 45);
        check("a5_nvalid", nv - bv, 1);
        check("a5_data", {24'd0, vdata[bv[3:0]]}, 32'hA5);
        check("a5_nfend", nf - bf, 1);
        check("a5_nerr", ne - be, 0);
        check("a5_fend_gap", f_cyc - v_cyc, 32);
        check("thomas_data", {24'd0, d1_data}, 32'h5A);
        half(1'b0, 45);

        mark();
        send_frame(16'hFF00, 16);
        half(line, 45);
        check("ff00_nvalid", nv - bv, 2);
        check("ff00_data0", {24'd0, vdata[bv[3:0]]}, 32'hFF);
        check("ff00_data1", {24'd0, vdata[4'(bv + 1)]}, 32'h00);
        check("ff00_nfend", nf - bf, 1);
        check("ff00_nerr", ne - be, 0);

        mark();
        send_bit(1'b1, 8, 8);
        send_bit(1'b1, 5, 8);
        send_bit(1'b0, 5, 11);
        send_bit(1'b1, 8, 11);
        send_bit(1'b0, 8, 8);
        send_bit(1'b0, 11, 8);
        send_bit(1'b1, 8, 8);
        send_bit(1'b0, 8, 8);
        send_bit(1'b1, 8, 8);
        half(line, 45);
        check("jit_nvalid", nv - bv, 1);
        check("jit_data", {24'd0, vdata[bv[3:0]]}, 32'hA5);
        check("jit_nerr", ne - be, 0);
        half(1'b0, 45);

        mark();
        half(1'b0, 8);
        half(1'b1, 3);
        half(1'b0, 45);
        check("bad_nerr", ne - be, 1);
        check("bad_busy", {31'd0, err_busy}, 32'h0);
        check("bad_nvalid", nv - bv, 0);
        check("bad_nfend", nf - bf, 0);

        mark();
        send_frame(16'h001A, 5);
        half(line, 45);
        check("trunc_nerr", ne - be, 1);
        check("trunc_nfend", nf - bf, 0);
        check("trunc_nvalid", nv - bv, 0);
        check("trunc_data", {24'd0, d0_data}, 32'hA5);
        half(1'b0, 45);

        send_frame(16'h0005, 3);
        check("mid_busy", {31'd0, d0_busy}, 32'h1);
        #3;
        rst = 1'b1;
        line = 1'b0;
        #1;
        check("arst_data", {24'd0, d0_data}, 32'h0);
        check("arst_busy", {31'd0, d0_busy}, 32'h0);
        check("arst_pulses", {29'd0, d0_valid, d0_err, d0_fend}, 32'h0);
        #9;
        rst = 1'b0;
        @(posedge clk);
        #1;
        half(1'b0, 40);

        mark();
        send_frame(16'h003C, 8);
        half(line, 45);
        check("post_nvalid", nv - bv, 1);
        check("post_data", {24'd0, vdata[bv[3:0]]}, 32'h3C);
        check("post_nfend", nf - bf, 1);
        check("post_nerr", ne - be, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
